// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Frame sequencer for an oversampled UART receive path. It synchronises the
// rx pin and validates the start bit at mid-bit. It then issues one-cycle
// strobes that load an external 9-bit shift register, checks the stop bit and
// optional even parity, and holds the finished frame under a valid/read
// handshake.
//
// Optional feature: define UART_RX_PARITY_EN to receive and check an even
// parity bit after the data bits. When it is undefined, there is no parity
// bit and parity_err is tied low.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame, LSB first (5..8)
//
// Ports:
//   clk          in   oversampling clock
//   rst          in   asynchronous active-low reset
//   rx           in   serial line, idle high, asynchronous to clk
//   read         in   host acknowledge, consumes the held frame
//   sr_clr       out  one-cycle clear to the shift register on start validation
//   shift_en     out  one-cycle shift strobe per data/parity bit
//   shift_bit    out  bit presented with shift_en
//   frame_valid  out  frame held, awaiting read
//   parity_err   out  parity mismatch on the held frame
//   frame_err    out  stop bit sampled low on the held frame
//   overrun      out  sticky: start edge seen while a frame was held
//   busy         out  high in every state except IDLE and HOLD
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic read,
    output logic sr_clr,
    output logic shift_en,
    output logic shift_bit,
    output logic frame_valid,
    output logic parity_err,
    output logic frame_err,
    output logic overrun,
    output logic busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s, rx_prev;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_end, mid_bit;
    logic             ovr_at_entry;   // overrun already reported when HOLD was entered
`ifdef UART_RX_PARITY_EN
    logic             par_acc;        // running XOR of the data bits
    logic             par_pend;       // parity mismatch waiting for the stop bit
`endif

    // Two-flop synchroniser plus edge history. All three flops reset to the
    // idle level so that leaving reset never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // pre-edge values. Blocking assignments here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall    = rx_prev & ~rx_s;
    assign bit_end = (cnt == CNT_LAST);
    assign mid_bit = (cnt == CNT_MID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block is given a default before the case
    // statement, so no path through it can infer a latch.
    always_comb begin
        state_next = state;
        sr_clr     = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fall) state_next = START;
            end
            START: begin
                if (mid_bit) begin
                    if (!rx_s) begin
                        sr_clr     = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;   // glitch, not a start bit
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    shift_en   = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) state_next = HOLD;
            end
            HOLD: begin
                busy = 1'b0;
                if (read) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign shift_bit = shift_en & rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            bit_idx      <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            ovr_at_entry <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc      <= 1'b0;
            par_pend     <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            // The bit timer restarts on every state change and wraps once per bit.
            if (state_next != state || bit_end) cnt <= '0;
            else                                cnt <= cnt + CNT_W'(1);

            if (sr_clr) begin
                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                par_acc <= 1'b0;
`endif
            end

            if (state == DATA && shift_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
                par_acc <= par_acc ^ rx_s;
`endif
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits XOR the parity bit must be 0.
            if (state == PARITY && shift_en) par_pend <= par_acc ^ rx_s;
`endif

            if (state == STOP && bit_end) begin
                frame_valid  <= 1'b1;
                frame_err    <= ~rx_s;
                ovr_at_entry <= overrun;
`ifdef UART_RX_PARITY_EN
                parity_err   <= par_pend;
`endif
            end

            if (state == HOLD) begin
                if (read) begin
                    frame_valid <= 1'b0;
                    frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    parity_err  <= 1'b0;
`endif
                    // Overrun survives the read of the frame it was reported
                    // with. It clears on the acknowledge of the next frame.
                    if (ovr_at_entry) overrun <= 1'b0;
                end
                if (fall) overrun <= 1'b1;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame sequencer for the oversampled serial receive path. Watches the `rx` line, validates the start bit at mid-bit, and emits one-cycle sample strobes that drive the external 9-bit receive shift register. It checks parity and stop, then holds the completed frame under a valid/read handshake. Sits between the raw `rx` pin and the shift register / host read logic, replacing ad-hoc counter decoding.

## Interface
- `CLKS_PER_BIT`, 20: clocks per serial bit. Must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first. Range 5–8.
- `clk`  in  1  receive oversampling clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `read`  in  1  host acknowledge; consumes the held frame.
- `sr_clr`  out  1  one-cycle clear pulse to the shift register on start validation.
- `shift_en`  out  1  one-cycle shift strobe per data/parity bit.
- `shift_bit`  out  1  sampled bit presented with `shift_en`.
- `frame_valid`  out  1  frame held in the shift register, awaiting `read`.
- `parity_err`  out  1  parity mismatch on the held frame.
- `frame_err`  out  1  stop bit sampled low on the held frame.
- `overrun`  out  1  sticky: start edge seen while a frame was held.
- `busy`  out  1  high in any state except IDLE and HOLD.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1), giving `rx_s`. Falling-edge detect compares `rx_s` against its previous value.
- Bit counter `cnt` is clog2(`CLKS_PER_BIT`) wide and counts 0..`CLKS_PER_BIT`-1. It clears on every state change. Let HALF = `CLKS_PER_BIT`/2.
- IDLE: on a falling edge of `rx_s`, go to START.
- START: when `cnt`==HALF-1, sample `rx_s`.
  - If it is 0: pulse `sr_clr` and go to DATA.
  - If it is 1: treat as a false start and return to IDLE. No outputs change.
- DATA: when `cnt`==`CLKS_PER_BIT`-1, pulse `shift_en` with `shift_bit`=`rx_s`. XOR the bit into the running parity and increment the bit index. After `DATA_BITS` strobes, go to PARITY (macro on) or STOP (macro off).
- PARITY: when `cnt`==`CLKS_PER_BIT`-1, pulse `shift_en` with the parity bit. Latch the even-parity mismatch into a pending flag. Go to STOP.
- STOP: when `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`. Go to HOLD and on the same edge:
  - set `frame_valid`;
  - set `frame_err` = ~`rx_s`;
  - set `parity_err` = the pending flag.
- HOLD: ignore `rx`, and emit no `shift_en`/`sr_clr` while held. This keeps the held frame from being clobbered.
  - A falling edge on `rx_s` in HOLD sets `overrun`.
  - `read` high: clear `frame_valid`, `parity_err` and `frame_err`, and go to IDLE on the next edge.
- `overrun` clears only when `read` occurs with `overrun` already set, i.e. on the acknowledge after the report.
- Other `read` cases:
  - `read` outside HOLD is ignored.
  - `read` held continuously consumes exactly one frame per HOLD entry.
- Unused state encodings go to IDLE.

## Timing
- Reset values: state IDLE, `cnt`=0, all outputs 0, synchronizer flops 1. Reset asserted mid-frame aborts immediately (asynchronous). The shift register is not cleared by this block on reset.
- Let t0 be the cycle the falling edge of `rx_s` is detected (2–3 clocks after the pin edge).
  - Start sample: t0+HALF.
  - Data bit k (0-based): t0+HALF+`CLKS_PER_BIT`·(k+1).
  - Parity: t0+HALF+`CLKS_PER_BIT`·(`DATA_BITS`+1).
  - Stop sample: t0+HALF+`CLKS_PER_BIT`·(`DATA_BITS`+P+1), where P=1 with the macro, 0 without. Defaults with parity: t0+210.
- `frame_valid` is registered: high on the cycle after the stop sample, low on the cycle after `read` is sampled.
- `sr_clr` and `shift_en` are strictly one clock wide and never coincide.
- Earliest next frame: a falling edge detected in the cycle after return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state compiled in and frame carries `DATA_BITS`+1 strobed bits;
  - even parity is checked and `parity_err` is live.
- Undefined:
  - PARITY state removed and only `DATA_BITS` strobes per frame;
  - `parity_err` is tied 0.

## Test plan
- Reset: hold `rst`=0 with `rx` toggling for 50 clocks -> all outputs 0, no strobes. Release -> still idle.
- Clean frame 0xA5, parity 0, stop 1 (defaults, macro on):
  - `sr_clr` at t0+10;
  - shift bits 1,0,1,0,0,1,0,1,0 at t0+30, 50…190;
  - `frame_valid`=1 at t0+211 with no errors;
  - `read` pulse -> valid low next cycle.
- False start: `rx` low for 6 clocks, then high -> return to IDLE at t0+10, no `sr_clr`, no strobes.
- Errors: send 0xA5 with parity 1 and stop 0 -> `parity_err`=1 and `frame_err`=1 with `frame_valid`. Both clear on `read`.
- Overrun: leave frame 1 unread and send frame 2 ->
  - `overrun`=1;
  - no `shift_en` during frame 2;
  - frame 1 bits intact;
  - `read` clears valid, and a second `read` after re-entry clears `overrun`.
- Reset mid-frame: assert `rst` at t0+100 -> outputs 0 asynchronously. A subsequent clean 0x3C frame is received correctly.
